// File: rtl/td4_pkg.sv
// Shared definitions for the TD4 program loader: program depth, default
// sync byte, loader and UART receiver state encodings, debug struct.
package td4_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         PROG_DEPTH        = 16;
  localparam int         ADDR_W            = $clog2(PROG_DEPTH);

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    RUN   = 2'd3
  } td4_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef struct packed {
    td4_state_e state;
    rx_state_e  rx_state;
  } td4_dbg_t;

endpackage

// File: rtl/td4_uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling after a 2-flop synchroniser.
// byte_valid / frame_err are single-cycle pulses at the stop-bit sample.
module td4_uart_rx
  import td4_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err,
  output rx_state_e  dbg_state
);

  localparam int                CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  rx_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;

  assign dbg_state = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      data       <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          // A start bit that is high again at mid-bit was a glitch.
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            data    <= {rx_sync, data[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_sync) byte_valid <= 1'b1;
            else         frame_err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/td4_prog_loader.sv
// UART-loaded 16x8 program memory for the TD4 core; holds the core in reset
// until a checksummed image arrives. Define TD4_LOADER_TIMEOUT_EN for the inter-byte timeout.
module td4_prog_loader
  import td4_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 104,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
`ifdef TD4_LOADER_TIMEOUT_EN
  ,
  parameter int         TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  input  logic [3:0] ip,
  output logic [7:0] ramdata,
  output logic       core_reset_n,
  output logic       loaded,
  output logic       load_err,
  output td4_dbg_t   dbg
);

  logic [7:0]        mem [PROG_DEPTH];
  logic [7:0]        rx_data;
  logic              byte_valid;
  logic              frame_err;
  rx_state_e         rx_state;
  td4_state_e        state;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        checksum;
  logic              wr_en;
  logic              timeout;
  logic              busy;

  td4_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .data       (rx_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .dbg_state  (rx_state)
  );

  assign ramdata = mem[ip];
  assign wr_en   = (state == LOAD) && byte_valid;
  assign busy    = (state == LOAD) || (state == CHECK);
  assign dbg     = {state, rx_state};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PROG_DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[addr] <= rx_data;
    end
  end

`ifdef TD4_LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                 to_cnt <= '0;
    else if (byte_valid || !busy) to_cnt <= '0;
    else                        to_cnt <= to_cnt + 1'b1;
  end

  // Fires TIMEOUT_CYCLES cycles after the last accepted byte.
  assign timeout = busy && !byte_valid && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= HOLD;
      core_reset_n <= 1'b0;
      loaded       <= 1'b0;
      load_err     <= 1'b0;
      addr         <= '0;
      checksum     <= '0;
    end else begin
      case (state)
        HOLD: begin
          if (byte_valid && rx_data == SYNC_BYTE) begin
            state    <= LOAD;
            addr     <= '0;
            checksum <= '0;
            load_err <= 1'b0;
          end
        end
        LOAD: begin
          if (frame_err || timeout) begin
            load_err <= 1'b1;
            state    <= HOLD;
          end else if (byte_valid) begin
            checksum <= checksum + rx_data;
            addr     <= addr + 1'b1;
            if (&addr) state <= CHECK;
          end
        end
        CHECK: begin
          if (frame_err || timeout) begin
            load_err <= 1'b1;
            state    <= HOLD;
          end else if (byte_valid) begin
            if (rx_data == checksum) begin
              state        <= RUN;
              loaded       <= 1'b1;
              core_reset_n <= 1'b1;
            end else begin
              load_err <= 1'b1;
              state    <= HOLD;
            end
          end
        end
        RUN: begin
          // Reload: core goes back into reset on the very next edge.
          if (byte_valid && rx_data == SYNC_BYTE) begin
            core_reset_n <= 1'b0;
            loaded       <= 1'b0;
            load_err     <= 1'b0;
            addr         <= '0;
            checksum     <= '0;
            state        <= LOAD;
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_td4_prog_loader.sv
// Randomized bench for td4_prog_loader: a byte-level loader model predicts
// status changes into a queue that a monitor pops whenever the outputs move.
module tb_td4_prog_loader;
  import td4_pkg::*;

  localparam int         CPB  = 8;
  localparam logic [7:0] SYNC = SYNC_BYTE_DEFAULT;
`ifdef TD4_LOADER_TIMEOUT_EN
  localparam int         TO   = 200;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rx    = 1'b1;
  logic [3:0] ip    = '0;
  logic [7:0] ramdata;
  logic       core_reset_n;
  logic       loaded;
  logic       load_err;
  td4_dbg_t   dbg;

  td4_prog_loader #(
    .CLKS_PER_BIT(CPB)
`ifdef TD4_LOADER_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rx           (rx),
    .ip           (ip),
    .ramdata      (ramdata),
    .core_reset_n (core_reset_n),
    .loaded       (loaded),
    .load_err     (load_err),
    .dbg          (dbg)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int win_lo   = 0;
  int win_hi   = 0;
  int last_t0  = 0;
  bit mon_en   = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // Status is {core_reset_n, loaded, load_err}.
  logic [2:0] exp_q[$];
  logic [7:0] m_mem[16];
  logic [2:0] m_st;
  int         m_mode;   // 0 idle/failed, 1 receiving image, 2 awaiting checksum, 3 running
  int         m_idx;
  logic [7:0] prog[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_sum();
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < 16; i++) s = s + m_mem[i];
    return s;
  endfunction

  function automatic void model_frame(input logic [7:0] b, input bit ferr);
    logic [2:0] prev;
    prev = m_st;
    case (m_mode)
      0: if (!ferr && b == SYNC) begin m_mode = 1; m_idx = 0; m_st = 3'b000; end
      1: begin
        if (ferr) begin m_st[0] = 1'b1; m_mode = 0; end
        else begin
          m_mem[m_idx] = b;
          m_idx++;
          if (m_idx == 16) m_mode = 2;
        end
      end
      2: begin
        if (!ferr && b == model_sum()) begin m_st = 3'b110; m_mode = 3; end
        else begin m_st[0] = 1'b1; m_mode = 0; end
      end
      default: if (!ferr && b == SYNC) begin m_mode = 1; m_idx = 0; m_st = 3'b000; end
    endcase
    if (m_st != prev) exp_q.push_back(m_st);
  endfunction

  // Monitor: every movement of the status outputs must match the next expectation.
  logic [2:0] last_st = 3'b000;
  always @(negedge clock) begin
    logic [2:0] cur;
    logic [2:0] e;
    cur = {core_reset_n, loaded, load_err};
    if (!mon_en) begin
      last_st = cur;
    end else if (cur !== last_st) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_status_change actual=%b required=%b (t=%0t)", cur, last_st, $time);
      end else begin
        e = exp_q.pop_front();
        check("status_change", 32'(cur), 32'(e));
        check("status_timing", 32'(cyc >= win_lo && cyc <= win_hi), 32'd1);
      end
      last_st = cur;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_bit);
    @(negedge clock);
    rx      = 1'b0;
    last_t0 = cyc;
    win_lo  = cyc + CPB * 9 + CPB / 2;
    win_hi  = cyc + CPB * 10 + 4;
    model_frame(b, !stop_bit);
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
    repeat ($urandom_range(4, 10)) @(negedge clock);
    check("expected_change_seen", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic send_load(input logic [7:0] sum);
    send_byte(SYNC, 1'b1);
    for (int i = 0; i < 16; i++) send_byte(prog[i], 1'b1);
    send_byte(sum, 1'b1);
  endtask

  task automatic check_status(input string tag);
    check(tag, 32'({core_reset_n, loaded, load_err}), 32'(m_st));
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 16; i++) begin
      ip = 4'(i);
      #1;
      check($sformatf("%s_ram%0d", tag, i), 32'(ramdata), 32'(m_mem[i]));
    end
    @(negedge clock);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    mon_en = 1'b0;
    reset  = 1'b0;
    rx     = 1'b1;
    repeat (3) @(negedge clock);
    m_mode = 0;
    m_idx  = 0;
    m_st   = 3'b000;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    exp_q.delete();
    reset = 1'b1;
    @(negedge clock);
    mon_en = 1'b1;
  endtask

  task automatic glitch();
    @(negedge clock);
    rx = 1'b0;
    repeat (2) @(negedge clock);
    rx = 1'b1;
    repeat (20) @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation did not complete");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] s;

    apply_reset();
    repeat (1000) @(negedge clock);
    check_status("reset_status");
    sweep("reset");

    // Ascending image with its correct checksum.
    for (int i = 0; i < 16; i++) prog[i] = 8'(i);
    send_load(8'h78);
    check_status("good_load_status");
    ip = 4'hA;
    #1;
    check("ip_A", 32'(ramdata), 32'h0A);
    sweep("good_load");

    // Junk byte in RUN is ignored, sync drops back into reset.
    send_byte(8'h3C, 1'b1);
    check_status("run_junk_status");
    send_byte(SYNC, 1'b1);
    check_status("run_resync_status");
    for (int i = 0; i < 16; i++) send_byte(prog[i], 1'b1);
    send_byte(8'h79, 1'b1);
    check_status("bad_sum_status");
    sweep("bad_sum");

    // Frame error on the sixth data byte.
    send_byte(SYNC, 1'b1);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b0);
    check_status("frame_err_status");
    check("frame_err_state", 32'(dbg.state), 32'(HOLD));
    sweep("frame_err");

    // Valid load with a short low glitch on the idle line mid-image.
    for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
    send_byte(SYNC, 1'b1);
    for (int i = 0; i < 16; i++) begin
      send_byte(prog[i], 1'b1);
      if (i == 7) glitch();
    end
    send_byte(model_sum(), 1'b1);
    check_status("glitch_load_status");
    sweep("glitch_load");

    // Randomized images, some containing the sync value, some with a bad checksum.
    for (int r = 0; r < 6; r++) begin
      b = 8'($urandom);
      if (b == SYNC) b = 8'h3C;
      send_byte(b, 1'b1);
      s = 8'h00;
      for (int i = 0; i < 16; i++) begin
        prog[i] = ($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom);
        s = s + prog[i];
      end
      send_load(($urandom_range(0, 1) == 1) ? s : s + 8'd1);
      check_status($sformatf("rand%0d_status", r));
      sweep($sformatf("rand%0d", r));
    end

    // Reset in the middle of a load wipes the image.
    send_byte(SYNC, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1);
    apply_reset();
    check_status("midload_reset_status");
    sweep("midload_reset");

`ifdef TD4_LOADER_TIMEOUT_EN
    send_byte(SYNC, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1);
    win_lo = last_t0 + CPB * 10 + TO - 6;
    win_hi = last_t0 + CPB * 10 + TO + 6;
    m_st[0] = 1'b1;
    m_mode  = 0;
    exp_q.push_back(m_st);
    repeat (TO + 40) @(negedge clock);
    check("timeout_change_seen", 32'(exp_q.size()), 32'd0);
    check_status("timeout_status");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
